// File: rtl/nvdla_glb_pkg.sv
// Shared constants and types for the GLB CSB slave: register offsets, request
// packet field positions and the response packet layout.
package nvdla_glb_pkg;

  localparam logic [9:0] OffsVersion = 10'h000;
  localparam logic [9:0] OffsMask    = 10'h001;
  localparam logic [9:0] OffsSet     = 10'h002;
  localparam logic [9:0] OffsStatus  = 10'h003;

  localparam int unsigned ReqPdW        = 63;
  localparam int unsigned ReqAddrLsb    = 0;
  localparam int unsigned ReqAddrMsb    = 21;
  localparam int unsigned ReqOffsMsb    = 9;
  localparam int unsigned ReqWdatLsb    = 22;
  localparam int unsigned ReqWdatMsb    = 53;
  localparam int unsigned ReqWriteBit   = 54;
  localparam int unsigned ReqNpostedBit = 55;
  localparam int unsigned ReqSrcprivBit = 56;
  localparam int unsigned ReqWrbeLsb    = 57;
  localparam int unsigned ReqLevelMsb   = 62;

  localparam int unsigned RspPdW = 34;

  localparam logic RspTypeRead  = 1'b0;
  localparam logic RspTypeWrAck = 1'b1;

  typedef struct packed {
    logic        typ;
    logic        err;
    logic [31:0] rdata;
  } glb_rsp_t;

  function automatic logic [9:0] req_word_offset(input logic [ReqPdW-1:0] pd);
    return pd[ReqOffsMsb:ReqAddrLsb];
  endfunction

endpackage

// File: rtl/nvdla_glb_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; pointers wrap naturally
// because the depth is a power of two.
module nvdla_glb_rsp_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic [Width-1:0] mem_q [Depth];
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(Depth));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  // Head is forced to zero when empty so the output is clean out of reset.
  assign rdata = empty ? '0 : mem_q[rptr_q];
  assign valid = ~empty;
  assign count = count_q;

endmodule

// File: rtl/nvdla_glb_csb_intr_ctrl.sv
// GLB CSB register slave: one-entry request stage, done status/mask/set
// registers, level interrupt and a credit-protected response FIFO.
module nvdla_glb_csb_intr_ctrl
  import nvdla_glb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned RSP_DEPTH = 4,
  parameter logic [31:0] HW_VER    = 32'h0001_0000
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  csb2glb_req_pvld,
  output logic                  csb2glb_req_prdy,
  input  logic [62:0]           csb2glb_req_pd,
  output logic                  glb2csb_resp_valid,
  input  logic                  glb2csb_resp_ready,
  output logic [33:0]           glb2csb_resp_pd,
  input  logic [2*NUM_CH-1:0]   done_status,
  output logic [2*NUM_CH-1:0]   done_mask,
  output logic                  core_intr
);

  localparam int unsigned StW  = 2 * NUM_CH;
  localparam int unsigned CntW = $clog2(RSP_DEPTH) + 1;

  logic            accept;
  logic            prdy_q, prdy_d;

  logic            s_valid_q;
  logic [9:0]      s_off_q;
  logic [31:0]     s_wdat_q;
  logic            s_write_q;
  logic            s_np_q;
  logic            s_wr_en;

  logic [StW-1:0]  status_q, status_d;
  logic [StW-1:0]  mask_q, mask_d;
  logic [StW-1:0]  set_bits, w1c_bits;
  logic            mask_wr;
  logic            intr_q;

  logic [31:0]     rdata;
  logic            err;
  glb_rsp_t        rsp;

  logic            push, pop, fifo_valid;
  logic [CntW-1:0] fifo_count, count_next;
  logic [RspPdW-1:0] fifo_head;

  logic            unused_pd;

  assign unused_pd = ^{csb2glb_req_pd[ReqLevelMsb:ReqSrcprivBit],
                       csb2glb_req_pd[ReqAddrMsb:ReqOffsMsb+1]};

  assign accept = csb2glb_req_pvld & prdy_q;

  // Request stage S: only the fields the decode needs are kept.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      s_valid_q <= 1'b0;
      s_off_q   <= '0;
      s_wdat_q  <= '0;
      s_write_q <= 1'b0;
      s_np_q    <= 1'b0;
    end else begin
      s_valid_q <= accept;
      if (accept) begin
        s_off_q   <= req_word_offset(csb2glb_req_pd);
        s_wdat_q  <= csb2glb_req_pd[ReqWdatMsb:ReqWdatLsb];
        s_write_q <= csb2glb_req_pd[ReqWriteBit];
        s_np_q    <= csb2glb_req_pd[ReqNpostedBit];
      end
    end
  end

  assign s_wr_en = s_valid_q & s_write_q;

  always_comb begin
    rdata    = '0;
    err      = 1'b0;
    mask_wr  = 1'b0;
    set_bits = '0;
    w1c_bits = '0;
    case (s_off_q)
      OffsVersion: rdata = HW_VER;
      OffsMask: begin
        rdata   = 32'(mask_q);
        mask_wr = s_wr_en;
      end
      OffsSet: begin
        if (s_wr_en) set_bits = s_wdat_q[StW-1:0];
      end
      OffsStatus: begin
        rdata = 32'(status_q);
        if (s_wr_en) w1c_bits = s_wdat_q[StW-1:0];
      end
      default: err = 1'b1;
    endcase
  end

  // Sets (hardware or software) take priority over a same-cycle W1C.
  assign status_d = (status_q & ~w1c_bits) | done_status | set_bits;
  assign mask_d   = mask_wr ? s_wdat_q[StW-1:0] : mask_q;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      status_q <= '0;
      mask_q   <= '0;
      intr_q   <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      intr_q   <= |(status_q & ~mask_q);
    end
  end

  always_comb begin
    rsp.typ   = s_write_q ? RspTypeWrAck : RspTypeRead;
    rsp.err   = err;
    rsp.rdata = s_write_q ? 32'h0 : rdata;
  end

  assign push = s_valid_q & (~s_write_q | s_np_q);
  assign pop  = fifo_valid & glb2csb_resp_ready;

  always_comb begin
    count_next = fifo_count;
    if (push & ~pop) count_next = fifo_count + CntW'(1);
    if (~push & pop) count_next = fifo_count - CntW'(1);
  end

  // Ready is registered from next-cycle occupancy, so it is low in reset and
  // rises the first cycle after.
  assign prdy_d = (32'(count_next) + 32'(accept)) < RSP_DEPTH;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) prdy_q <= 1'b0;
    else                prdy_q <= prdy_d;
  end

  nvdla_glb_rsp_fifo #(
    .Width (RspPdW),
    .Depth (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (push),
    .wdata (rsp),
    .pop   (pop),
    .rdata (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign csb2glb_req_prdy   = prdy_q;
  assign glb2csb_resp_valid = fifo_valid;
  assign glb2csb_resp_pd    = fifo_head;
  assign done_mask          = mask_q;
  assign core_intr          = intr_q;

endmodule
